// File: rtl/fb_rd_arbiter_if.sv
// ============================================================================
//  Module   : fb_rd_arbiter_if
//  Purpose  : Bundles the two requester handshakes and the mem0 read port
//             that fb_rd_arbiter sits between.
//  Signals  :
//    r0_req/r0_addr/r0_gnt/r0_rvalid  requester 0 (VGA pixel stream)
//    r1_req/r1_addr/r1_gnt/r1_rvalid  requester 1 (LeNet capture path)
//    mem_en/mem_addr/mem_rdata        mem0 BRAM synchronous read port
//    rdata                            read data shared by both requesters
//    r1_starved                       pulse on entry to a forced r1 burst
//  Modports : slave  - arbiter view
//             master - requester/memory side view (testbench, top level)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fb_rd_arbiter_if;
  logic        r0_req;
  logic [18:0] r0_addr;
  logic        r0_gnt;
  logic        r0_rvalid;

  logic        r1_req;
  logic [18:0] r1_addr;
  logic        r1_gnt;
  logic        r1_rvalid;

  logic        mem_en;
  logic [18:0] mem_addr;
  logic [7:0]  mem_rdata;

  logic [7:0]  rdata;
  logic        r1_starved;

  modport slave (
    input  r0_req, r0_addr, r1_req, r1_addr, mem_rdata,
    output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid,
    output mem_en, mem_addr, rdata, r1_starved
  );

  modport master (
    output r0_req, r0_addr, r1_req, r1_addr, mem_rdata,
    input  r0_gnt, r0_rvalid, r1_gnt, r1_rvalid,
    input  mem_en, mem_addr, rdata, r1_starved
  );
endinterface

`default_nettype wire

// File: rtl/fb_rd_arbiter.sv
// ============================================================================
//  Module   : fb_rd_arbiter
//  Purpose  : Shares the single mem0 read port between the VGA pixel stream
//             (r0, fixed priority) and the LeNet capture path (r1). r1 gets
//             a bounded-latency burst after MAX_WAIT denied cycles.
//  Params   : READ_LAT  cycles from mem_en/mem_addr to valid mem_rdata (1..4)
//             MAX_WAIT  denied r1 cycles that force an r1 burst      (1..255)
//             BURST     max r1 grants per forced burst               (1..255)
//  Ports    : clk25     pixel clock
//             rst_n     asynchronous active-low reset
//             bus       fb_rd_arbiter_if.slave (requesters + mem0 port)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_rd_arbiter #(
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned BURST    = 4
) (
  input  wire logic      clk25,
  input  wire logic      rst_n,
  fb_rd_arbiter_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0] c_ST_PRI0   = 1'b0;  // r0 has priority
  localparam logic [0:0] c_ST_FORCE1 = 1'b1;  // forced r1 burst

  localparam logic [7:0] c_MAX_WAIT  = 8'(MAX_WAIT);
  localparam logic [7:0] c_BURST     = 8'(BURST);
  localparam int         c_TAG_LAST  = int'(READ_LAT) - 1;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_nxt;
  logic [7:0]  w_wait_inc;
  logic [7:0]  r_burst_cnt;
  logic [7:0]  w_burst_nxt;
  logic [7:0]  w_burst_inc;
  logic        w_starve_entry;
  logic        r_starved;

  logic        w_r0_gnt;
  logic        w_r1_gnt;
  logic        w_any_gnt;

  logic        r_mem_en;
  logic [18:0] r_mem_addr;
  logic        r_mem_own1;   // owner of the read currently presented to mem0

  // Owner tag pipeline, one entry per cycle of memory latency: {r1, r0}.
  logic [1:0]  r_tag [READ_LAT];

  // --------------------------------------------------------------------------
  // Grant selection (combinational from requests and state)
  // --------------------------------------------------------------------------
  always_comb begin
    w_r0_gnt = 1'b0;
    w_r1_gnt = 1'b0;
    if (r_state == c_ST_FORCE1) begin
      w_r1_gnt = bus.r1_req;
      w_r0_gnt = bus.r0_req & ~bus.r1_req;
    end else begin
      w_r0_gnt = bus.r0_req;
      w_r1_gnt = bus.r1_req & ~bus.r0_req;
    end
  end

  assign w_any_gnt  = w_r0_gnt | w_r1_gnt;
  assign bus.r0_gnt = w_r0_gnt;
  assign bus.r1_gnt = w_r1_gnt;

  // --------------------------------------------------------------------------
  // Anti-starvation state machine
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_nxt     = r_wait_cnt;
    w_burst_nxt    = r_burst_cnt;
    w_starve_entry = 1'b0;
    w_wait_inc     = r_wait_cnt + 8'd1;
    w_burst_inc    = r_burst_cnt + 8'd1;

    case (r_state)
      c_ST_PRI0: begin
        w_burst_nxt = 8'd0;
        if (w_r1_gnt) begin
          w_wait_nxt = 8'd0;
        end else if (bus.r1_req) begin
          // The transition takes precedence over the count: the counter
          // lands on zero, ready for the next PRI0 episode.
          if (w_wait_inc == c_MAX_WAIT) begin
            w_state_nxt    = c_ST_FORCE1;
            w_wait_nxt     = 8'd0;
            w_starve_entry = 1'b1;
          end else begin
            w_wait_nxt = w_wait_inc;
          end
        end
      end

      default: begin
        // FORCE1: r1 is always granted while it requests, so every cycle
        // with r1_req high is a burst grant. Dropping r1_req ends the burst.
        w_wait_nxt = 8'd0;
        if (!bus.r1_req) begin
          w_state_nxt = c_ST_PRI0;
          w_burst_nxt = 8'd0;
        end else if (w_burst_inc == c_BURST) begin
          w_state_nxt = c_ST_PRI0;
          w_burst_nxt = 8'd0;
        end else begin
          w_burst_nxt = w_burst_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_PRI0;
      r_wait_cnt  <= 8'd0;
      r_burst_cnt <= 8'd0;
      r_starved   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_starved   <= w_starve_entry;
    end
  end

  assign bus.r1_starved = r_starved;

  // --------------------------------------------------------------------------
  // mem0 request register: address holds its last value when idle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en   <= 1'b0;
      r_mem_addr <= 19'd0;
      r_mem_own1 <= 1'b0;
    end else begin
      r_mem_en   <= w_any_gnt;
      r_mem_own1 <= w_r1_gnt;
      if (w_r1_gnt) begin
        r_mem_addr <= bus.r1_addr;
      end else if (w_r0_gnt) begin
        r_mem_addr <= bus.r0_addr;
      end
    end
  end

  assign bus.mem_en   = r_mem_en;
  assign bus.mem_addr = r_mem_addr;

  // --------------------------------------------------------------------------
  // Owner tag pipeline. Stage 0 captures the owner of the read presented to
  // mem0 this cycle; the last stage lines up with valid mem_rdata. Only one
  // read enters per cycle, so the two valid bits are mutually exclusive and
  // returns come out in grant order. Reset flushes all in-flight tags.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(READ_LAT); i++) begin
        r_tag[i] <= 2'b00;
      end
    end else begin
      r_tag[0] <= {r_mem_en & r_mem_own1, r_mem_en & ~r_mem_own1};
      for (int i = 1; i < int'(READ_LAT); i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign bus.r0_rvalid = r_tag[c_TAG_LAST][0];
  assign bus.r1_rvalid = r_tag[c_TAG_LAST][1];

  // Read data is shared; the rvalid flags say who owns it.
  assign bus.rdata = bus.mem_rdata;

endmodule

`default_nettype wire

// File: doc/fb_rd_arbiter.md
# fb_rd_arbiter

Read-port arbiter for the camera frame buffer (mem0: 19-bit address, 8-bit pixel, synchronous read). It shares the single read port between two requesters. Requester 0 is the pixel-processing stream that feeds the VGA output buffer and has fixed priority. Requester 1 is the LeNet capture path that fetches pixels when a classification is triggered, and an anti-starvation scheme guarantees it a bounded-latency burst. The block sits between both requesters and the mem0 BRAM read port, all in the clk25 domain.

## Interface
- READ_LAT, 1: cycles from mem_en/mem_addr to valid mem_rdata (1..4)
- MAX_WAIT, 16: denied r1 cycles that force an r1 burst (1..255)
- BURST, 4: max r1 grants per forced burst (1..255)

Ports:
- clk25  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- r0_req  in  1  requester 0 read request
- r0_addr  in  19  requester 0 pixel address
- r0_gnt  out  1  r0 request accepted this cycle (combinational)
- r0_rvalid  out  1  rdata belongs to r0
- r1_req  in  1  requester 1 read request
- r1_addr  in  19  requester 1 pixel address
- r1_gnt  out  1  r1 request accepted this cycle (combinational)
- r1_rvalid  out  1  rdata belongs to r1
- mem_en  out  1  read enable to mem0 (registered)
- mem_addr  out  19  read address to mem0 (registered)
- mem_rdata  in  8  mem0 read data
- rdata  out  8  equals mem_rdata (pass-through)
- r1_starved  out  1  one-cycle pulse on entry to the forced-burst state

## Operation
- Requesters hold req and addr until gnt. One grant at most per cycle. A request is accepted in any cycle where req and gnt are both high.
- State PRI0 (reset state):
  - r0_req wins whenever it is high.
  - r1 is granted only if r0_req is low.
  - wait_cnt (8 bit) increments each cycle r1_req=1 and r1_gnt=0. It clears on any r1 grant.
  - When the incremented wait_cnt equals MAX_WAIT: next state is FORCE1, r1_starved=1 for one cycle, and wait_cnt clears.
- State FORCE1:
  - r1_req wins. r0 is granted only if r1_req is low.
  - burst_cnt counts r1 grants.
  - Return to PRI0 after the grant that makes burst_cnt==BURST, or in any cycle r1_req=0. burst_cnt clears on exit.
- Granted address registers to mem_addr with mem_en=1 in the next cycle.
- With no grant, mem_en=0 and mem_addr holds its last value.
- An owner tag pipeline of depth READ_LAT tracks in-flight reads. r0_rvalid/r1_rvalid assert exactly READ_LAT cycles after the matching mem_en cycle. They are never both high.
- Reads return strictly in grant order, with one read in flight per cycle at most (full throughput, back-to-back grants allowed).

## Timing
- Grant-to-data latency: grant at T, mem_en at T+1, rvalid at T+1+READ_LAT (T+2 by default).
- r0_gnt/r1_gnt are combinational from req and state. All other outputs are registered.
- Reset values: mem_en=0, mem_addr=0, r0_rvalid=0, r1_rvalid=0, r1_starved=0, state PRI0, wait_cnt=0, burst_cnt=0. rdata follows mem_rdata. Gnt outputs are 0 while both reqs are low.
- Reset mid-operation flushes the tag pipeline. No rvalid is emitted for reads issued before reset.
- r0 starvation bound: while in FORCE1, r0 waits at most BURST cycles.
- r1 wait bound in PRI0: MAX_WAIT cycles, then its grant arrives in the first FORCE1 cycle.
- Simultaneous req in PRI0: r0 wins. In FORCE1: r1 wins.
- MAX_WAIT=1: a single denied cycle forces FORCE1.
- A wait_cnt increment and the transition in the same cycle: the transition wins and wait_cnt becomes 0.

## Test plan
- Single r0 read, r1 idle: r0_req, r0_addr=0x00010 at T, mem preloaded with 0xA5. Required: r0_gnt at T, mem_en/mem_addr=0x00010 at T+1, r0_rvalid and rdata=0xA5 at T+2, r1_rvalid stays 0.
- Back-to-back stream: r0 reads addresses 0..639 continuously. Required: 640 consecutive mem_en cycles and 640 r0_rvalid pulses, data in address order, no gaps.
- Starvation: r0_req held high, r1_req held high from cycle 0, defaults. Required: r1_starved pulses once after 16 denied cycles, then 4 consecutive r1 grants, then r0 regains grants. The pattern repeats (16 r0 / 4 r1).
- Early burst exit: as the starvation test, but drop r1_req after 2 forced grants. Required: return to PRI0 at once, r0 granted the same cycle r1_req=0, wait_cnt restarts from 0.
- Interleaved returns with READ_LAT=3: alternate r0 and r1 grants (r1 only when r0_req low). Required: each rvalid 4 cycles after its grant, tagged to the correct requester, never both high.
- Reset mid-flight: assert rst_n low one cycle after an r1 grant. Required: mem_en=0 and all rvalid=0 immediately, and no rvalid after reset release until a new grant.
